// File: rtl/alu_pkg.sv
// Shared definitions for the streaming FP ALU: FSM state encodings,
// opcodes, the canonical quiet NaN and a NaN detector.
package alu_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD_A = 4'd1,
        S_LOAD_B = 4'd2,
        S_EXEC   = 4'd3,
        S_OUTPUT = 4'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MIN = 2'b10;
    localparam logic [1:0] OP_MAX = 2'b11;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/fp_addsub.sv
// Combinational IEEE-754 single-precision add/subtract, round-to-nearest-even.
// Ports: a, b operands; sub negates b; result = a +/- b.
module fp_addsub
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] result
);

    logic        sa, sb, sl, ss, stk, rup;
    logic [7:0]  ea, eb, el, es, diff;
    logic [23:0] ma, mb, ml, msm;
    logic [26:0] xl, xs, mask, n;
    logic [27:0] sum;
    logic [4:0]  lz, sh;
    logic [9:0]  e;
    logic [24:0] rm;

    always_comb begin
        sa  = a[31];
        sb  = b[31] ^ sub;
        // Denormals use an effective exponent of 1 and no hidden bit.
        ea  = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        eb  = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        ma  = {a[30:23] != 8'd0, a[22:0]};
        mb  = {b[30:23] != 8'd0, b[22:0]};
        if (a[30:0] >= b[30:0]) begin
            sl = sa; el = ea; ml = ma;
            ss = sb; es = eb; msm = mb;
        end else begin
            sl = sb; el = eb; ml = mb;
            ss = sa; es = ea; msm = ma;
        end
        diff = el - es;
        xl   = {ml, 3'b000};
        mask = '0;
        stk  = 1'b0;
        if (diff >= 8'd27) begin
            xs = {26'd0, |msm};
        end else begin
            mask = (27'd1 << diff) - 27'd1;
            stk  = |({msm, 3'b000} & mask);
            xs   = {msm, 3'b000} >> diff;
            xs[0] = xs[0] | stk;
        end
        if (sl == ss) sum = {1'b0, xl} + {1'b0, xs};
        else          sum = {1'b0, xl} - {1'b0, xs};

        e  = {2'b00, el};
        n  = sum[26:0];
        lz = '0;
        sh = '0;
        if (sum[27]) begin
            n = sum[27:1] | {26'd0, sum[0]};
            e = e + 10'd1;
        end else begin
            for (int i = 0; i <= 26; i++)
                if (sum[i]) lz = 5'(26 - i);
            // Never normalise below the minimum exponent: yields denormals.
            sh = ({5'd0, lz} > e - 10'd1) ? 5'(e - 10'd1) : lz;
            n  = n << sh;
            e  = e - {5'd0, sh};
        end

        rup = n[2] & (n[1] | n[0] | n[3]);
        rm  = {1'b0, n[26:3]} + {24'd0, rup};
        if (rm[24]) begin
            rm = rm >> 1;
            e  = e + 10'd1;
        end

        if (is_nan(a) || is_nan(b))
            result = QNAN;
        else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && sa != sb)
            result = QNAN;
        else if (a[30:23] == 8'hFF)
            result = {sa, a[30:0]};
        else if (b[30:23] == 8'hFF)
            result = {sb, b[30:0]};
        else if (sum == 28'd0)
            result = {sl & ss, 31'd0};
        else if (e >= 10'd255)
            result = {sl, 8'hFF, 23'd0};
        else
            result = {sl, rm[23] ? e[7:0] : 8'd0, rm[22:0]};
    end

endmodule

// File: rtl/fp_alu_stream.sv
// Streaming FP ALU: loads two 32-bit operands as BUS_W beats, computes
// add/sub/min/max, and streams the result out LSB beat first.
// Ports: clk, rst_n; start/opcode request; in_data/in_valid/in_ready
// operand stream; out_data/out_valid/out_ready result stream;
// busy, done, state_out status.
module fp_alu_stream
    import alu_pkg::*;
#(
    parameter int BUS_W    = 8,
    parameter int EXEC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       opcode,
    input  logic [BUS_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [3:0]       state_out
);

    localparam int         BEATS    = 32 / BUS_W;
    localparam logic [2:0] LAST     = 3'(BEATS - 1);
    localparam logic [3:0] LAT_LAST = 4'(EXEC_LAT - 1);

    state_t      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic [3:0]  lat_q, lat_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [31:0] addsub_res, minmax_res, exec_res;
    logic        a_lt_b;

    fp_addsub u_addsub (
        .a      (a_q),
        .b      (b_q),
        .sub    (op_q == OP_SUB),
        .result (addsub_res)
    );

    // Sign-magnitude ordering, so -0 sorts below +0.
    always_comb begin
        if (a_q[31] != b_q[31]) a_lt_b = a_q[31];
        else if (a_q[31])       a_lt_b = a_q[30:0] > b_q[30:0];
        else                    a_lt_b = a_q[30:0] < b_q[30:0];
        if (is_nan(a_q) || is_nan(b_q))
            minmax_res = QNAN;
        else if (op_q == OP_MIN)
            minmax_res = a_lt_b ? a_q : b_q;
        else
            minmax_res = a_lt_b ? b_q : a_q;
        exec_res = op_q[1] ? minmax_res : addsub_res;
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = opcode;
                    beat_d  = '0;
                    lat_d   = '0;
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A, S_LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (state_q == S_LOAD_A)
                        a_d[int'(beat_q)*BUS_W +: BUS_W] = in_data;
                    else
                        b_d[int'(beat_q)*BUS_W +: BUS_W] = in_data;
                    if (beat_q == LAST) begin
                        beat_d  = '0;
                        state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_EXEC;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            S_EXEC: begin
                if (lat_q == LAT_LAST) begin
                    res_d   = exec_res;
                    lat_d   = '0;
                    state_d = S_OUTPUT;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            S_OUTPUT: begin
                out_valid = 1'b1;
                out_data  = res_q[int'(beat_q)*BUS_W +: BUS_W];
                if (out_ready) begin
                    if (beat_q == LAST) begin
                        done    = 1'b1;
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign state_out = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: doc/fp_alu_stream.md
FP_ALU_STREAM -- requirements
Module: fp_alu_stream

Interface
REQ-001 Parameter BUS_W, default 8, data bus width in bits; legal values 8, 16, 32.
REQ-002 Parameter EXEC_LAT, default 1, cycles from EXEC entry to result capture; legal range 1..15.
REQ-003 clk  input  1  rising-edge clock, the only clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request for a new operation; sampled only in IDLE.
REQ-006 opcode  input  2  operation: 00 add, 01 sub, 10 min, 11 max; latched when start is accepted.
REQ-007 in_data  input  BUS_W  operand beat.
REQ-008 in_valid  input  1  in_data is valid.
REQ-009 in_ready  output  1  block accepts an operand beat this cycle.
REQ-010 out_data  output  BUS_W  result beat.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  consumer accepts a result beat.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse in the cycle the last result beat transfers.
REQ-015 state_out  output  4  current FSM state encoding, for debug.

Function
REQ-016 Derived constant BEATS = 32/BUS_W; all operands and results are IEEE-754 single precision (32 bits).
REQ-017 FSM states and encodings: IDLE=0, LOAD_A=1, LOAD_B=2, EXEC=3, OUTPUT=4.
REQ-018 IDLE: start=1 latches opcode, clears the beat counter and goes to LOAD_A in the next cycle.
REQ-019 in_ready is 1 only in LOAD_A and LOAD_B; a beat transfers only when in_valid and in_ready are both 1; in_valid=0 stalls the block with no state change.
REQ-020 Beats transfer least-significant first; beat k fills bits [k*BUS_W +: BUS_W].
REQ-021 After BEATS transfers the FSM moves LOAD_A->LOAD_B or LOAD_B->EXEC, and the beat counter wraps to 0.
REQ-022 EXEC: a latency counter runs for exactly EXEC_LAT cycles, then the result register is captured and the FSM enters OUTPUT.
REQ-023 add/sub results come from the fp_addsub sub-module; sub is asserted when the latched opcode is 01.
REQ-024 min/max compare sign-magnitude: -0 < +0, so min(+0,-0) = 0x80000000 and max(+0,-0) = 0x00000000.
REQ-025 min/max with either operand NaN (exp=FF, mantissa!=0) returns canonical qNaN 0x7FC00000.
REQ-026 OUTPUT: out_valid=1 and out_data = current result beat (LSB first); the beat advances only when out_ready=1.
REQ-027 While out_ready=0, out_data and out_valid are held stable.
REQ-028 On the last beat transfer: done=1 for that cycle, then the FSM returns to IDLE.
REQ-029 start is ignored in every state except IDLE, including the cycle done=1.
REQ-030 opcode changes after acceptance have no effect on the running operation.
REQ-031 Minimum total latency, start accepted to done, with no stalls: 1 + 2*BEATS + EXEC_LAT + BEATS cycles.

Reset
REQ-032 rst_n=0 immediately forces the FSM to IDLE, clears both counters, both operand registers and the result register, and drives in_ready, out_valid, busy and done to 0, out_data to 0 and state_out to 0.
REQ-033 Reset asserted mid-load, mid-EXEC or mid-output aborts the operation with no partial output; the block is ready for start in the first cycle after rst_n rises.

Structure
REQ-034 Package alu_pkg holds: the FSM state encodings, the opcode constants, QNAN = 0x7FC00000, and a function that detects NaN.
REQ-035 Exactly one sub-module is instantiated: the existing combinational fp_addsub (ports a, b, sub, result); min/max logic sits inline in the block.

Verification
REQ-036 BUS_W=8, add, A beats 00 00 80 3F (1.0), B beats 00 00 00 40 (2.0) -> out beats 00 00 40 40 (3.0); done pulses on beat 4.
REQ-037 BUS_W=16, sub, A = 0x40400000, B = 0x3F800000 -> out beats 0000, 4000; with no stalls, done occurs 1+4+EXEC_LAT+2 cycles after start is accepted.
REQ-038 max(-1.0 = 0xBF800000, 2.0 = 0x40000000) -> 0x40000000; min(0x00000000, 0x80000000) -> 0x80000000; min(0x7FC00001, 1.0) -> 0x7FC00000.
REQ-039 out_ready held 0 for 5 cycles during beat 2 -> out_data stable throughout, no beat lost or repeated, done only on the final transfer.
REQ-040 in_valid gaps during LOAD_B, and start pulses while busy -> result unchanged and no second operation starts.
REQ-041 rst_n pulsed low during LOAD_B beat 2 -> all outputs 0 at once; a new add of 1.0+1.0 afterwards returns 0x40000000.
